// File: rtl/spi_master_mode.sv
// rtl/spi_master_mode.sv - SPI master with selectable CPOL/CPHA, bit order, divider and slave select
module spi_master_mode #(
    parameter int DWIDTH = 8,
    parameter int NCS    = 2,
    parameter int DIV_W  = 8,
    localparam int CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DWIDTH-1:0] din,
    input  logic [CSW-1:0]    cs_sel,
    input  logic [1:0]        mode,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  div,
    output logic [DWIDTH-1:0] dout,
    output logic              busy,
    output logic              done,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic [NCS-1:0]    ss_n
);

    localparam int EW = $clog2(2 * DWIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DWIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_cnt;
    logic [EW-1:0]     r_edge;
    logic [DWIDTH-1:0] r_tx;
    logic [DWIDTH-1:0] r_rx;
    logic [DWIDTH-1:0] r_dout;
    logic              r_cpha;
    logic              r_lsb;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_busy;
    logic              r_done;
    logic [NCS-1:0]    r_ss_n;

    logic              w_cs_ok;
    logic              w_period_end;
    logic [EW-1:0]     w_edge_next;
    logic              w_leading;
    logic              w_present;
    logic              w_sample;
    logic              w_tx_bit;
    logic [DWIDTH-1:0] w_tx_shift;
    logic [DWIDTH-1:0] w_rx_next;
    logic              w_din_first;
    logic [DWIDTH-1:0] w_din_shift;

    assign w_cs_ok      = int'(cs_sel) < NCS;
    assign w_period_end = (r_cnt == r_div);
    assign w_edge_next  = r_edge + 1'b1;
    assign w_leading    = w_edge_next[0];

    // CPHA=0 presents bit 0 at SETUP entry, so trailing edges only carry bits 1..DWIDTH-1
    assign w_present = r_cpha ? w_leading : (!w_leading && (w_edge_next != LAST_EDGE));
    assign w_sample  = r_cpha ? !w_leading : w_leading;

    assign w_tx_bit    = r_lsb ? r_tx[0] : r_tx[DWIDTH-1];
    assign w_tx_shift  = r_lsb ? (r_tx >> 1) : (r_tx << 1);
    assign w_rx_next   = r_lsb ? {miso, r_rx[DWIDTH-1:1]} : {r_rx[DWIDTH-2:0], miso};
    assign w_din_first = lsb_first ? din[0] : din[DWIDTH-1];
    assign w_din_shift = lsb_first ? (din >> 1) : (din << 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_dout  <= '0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ss_n  <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= mode[1];
                    if (wr && w_cs_ok) begin
                        r_state <= SETUP;
                        r_busy  <= 1'b1;
                        r_ss_n  <= ~(NCS'(1) << cs_sel);
                        r_div   <= div;
                        r_cnt   <= '0;
                        r_edge  <= '0;
                        r_rx    <= '0;
                        r_cpha  <= mode[0];
                        r_lsb   <= lsb_first;
                        if (mode[0]) begin
                            r_tx <= din;
                        end else begin
                            r_mosi <= w_din_first;
                            r_tx   <= w_din_shift;
                        end
                    end
                end
                SETUP: begin
                    if (w_period_end) begin
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_period_end) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        r_edge <= w_edge_next;
                        if (w_present) begin
                            r_mosi <= w_tx_bit;
                            r_tx   <= w_tx_shift;
                        end
                        if (w_sample) begin
                            r_rx <= w_rx_next;
                        end
                        if (w_edge_next == LAST_EDGE) begin
                            r_state <= HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (w_period_end) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ss_n  <= '1;
                        r_done  <= 1'b1;
                        r_dout  <= r_rx;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dout = r_dout;
    assign busy = r_busy;
    assign done = r_done;
    assign mosi = r_mosi;
    assign sclk = r_sclk;
    assign ss_n = r_ss_n;

endmodule

// File: tb/tb_spi_master_mode.sv
// tb/tb_spi_master_mode.sv - directed scoreboard bench for spi_master_mode with an SPI slave model
module tb_spi_master_mode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] din = '0;
    logic [1:0] cs_sel = '0;
    logic [1:0] mode = '0;
    logic       lsb_first = 1'b0;
    logic [7:0] div = '0;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       miso;
    logic       mosi;
    logic       sclk;
    logic [2:0] ss_n;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    spi_master_mode #(.DWIDTH(8), .NCS(3), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .cs_sel(cs_sel),
        .mode(mode), .lsb_first(lsb_first), .div(div), .dout(dout),
        .busy(busy), .done(done), .miso(miso), .mosi(mosi),
        .sclk(sclk), .ss_n(ss_n)
    );

    // Slave: drives its word MSB-first on the wire, captures mosi in wire order
    logic       s_sel;
    int         s_edges = 0;
    int         s_rise = 0;
    int         s_idx;
    logic [7:0] s_word = '0;
    logic [7:0] s_rx = '0;
    logic       s_loop = 1'b0;
    logic       s_cpha = 1'b0;
    logic       s_bit;

    assign s_sel = ~&ss_n;

    always @(posedge s_sel) begin
        s_edges = 0;
        s_rise  = 0;
        s_rx    = '0;
    end

    always @(sclk) begin
        if (s_sel && !rst) begin
            s_edges = s_edges + 1;
            if (sclk) s_rise = s_rise + 1;
            if (((s_edges % 2) == 1) != s_cpha) s_rx = {s_rx[6:0], mosi};
        end
    end

    always_comb begin
        s_idx = s_cpha ? ((s_edges == 0) ? 0 : (s_edges - 1) / 2) : s_edges / 2;
        if (s_idx > 7) s_idx = 7;
        s_bit = s_word[3'(7 - s_idx)];
    end

    assign miso = s_loop ? mosi : s_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer_start(input logic [7:0] d, input logic [1:0] cs, input logic [1:0] m,
                              input logic lsb, input logic [7:0] dv, input logic [7:0] word,
                              input logic loop, input bit push, input logic [7:0] exp);
        @(negedge clk);
        mode = m;
        lsb_first = lsb;
        div = dv;
        s_word = word;
        s_loop = loop;
        s_cpha = m[0];
        @(negedge clk);
        din = d;
        cs_sel = cs;
        wr = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic xfer_finish(input int already, input int exp_busy, input string tag);
        int n;
        logic [7:0] e;
        n = already;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, n, exp_busy);
        chk({tag, " done"}, done, 1);
        e = 8'hxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, " dout"}, dout, e);
    endtask

    initial begin
        int n;
        int n_done;
        logic [1:0] mm;

        repeat (3) @(negedge clk);
        chk("rst sclk", sclk, 0);
        chk("rst mosi", mosi, 0);
        chk("rst ss_n", ss_n, 3'b111);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst dout", dout, 0);
        rst = 1'b0;

        xfer_start(8'hA5, 2'd0, 2'b00, 1'b0, 8'd1, 8'h00, 1'b1, 1'b1, 8'hA5);
        chk("a5 busy", busy, 1);
        chk("a5 ss_n", ss_n, 3'b110);
        xfer_finish(0, 36, "a5");
        chk("a5 mosi_bits", s_rx, 8'hA5);
        chk("a5 rising_edges", s_rise, 8);
        chk("a5 idle_sclk", sclk, 0);

        for (int m = 1; m < 4; m++) begin
            mm = 2'(m);
            xfer_start(8'h3C, 2'd1, mm, 1'b0, 8'd2, 8'hC3, 1'b0, 1'b1, 8'hC3);
            chk("mode ss_n", ss_n, 3'b101);
            xfer_finish(0, 54, "mode");
            chk("mode mosi_bits", s_rx, 8'h3C);
            chk("mode idle_sclk", sclk, mm[1]);
        end

        xfer_start(8'h01, 2'd0, 2'b00, 1'b1, 8'd1, 8'h80, 1'b0, 1'b1, 8'h01);
        xfer_finish(0, 36, "lsb");
        chk("lsb mosi_bits", s_rx, 8'h80);

        xfer_start(8'h96, 2'd2, 2'b00, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 8'h96);
        chk("cs2 ss_n", ss_n, 3'b011);
        xfer_finish(0, 18, "cs2");

        @(negedge clk);
        cs_sel = 2'd3;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        chk("cs3 busy", busy, 0);
        chk("cs3 ss_n", ss_n, 3'b111);
        repeat (3) @(negedge clk);
        chk("cs3 done", done, 0);

        xfer_start(8'h5A, 2'd0, 2'b00, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 8'h5A);
        @(negedge clk);
        din = 8'hFF;
        cs_sel = 2'd1;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        repeat (2) @(negedge clk);
        chk("ignore ss_n", ss_n, 3'b110);
        xfer_finish(4, 18, "ignore");
        chk("b2b gap ss_n", ss_n, 3'b111);
        din = 8'h81;
        cs_sel = 2'd0;
        wr = 1'b1;
        exp_q.push_back(8'h81);
        @(negedge clk);
        wr = 1'b0;
        chk("b2b busy", busy, 1);
        chk("b2b ss_n", ss_n, 3'b110);
        xfer_finish(0, 18, "b2b");

        xfer_start(8'hE7, 2'd0, 2'b10, 1'b0, 8'd3, 8'h00, 1'b1, 1'b0, 8'h00);
        n = 0;
        while (s_edges != 5 && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk("abort reached_edge5", s_edges, 5);
        #2 rst = 1'b1;
        #1;
        chk("abort ss_n", ss_n, 3'b111);
        chk("abort sclk", sclk, 0);
        chk("abort busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (100) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        chk("abort no_done", n_done, 0);
        chk("abort dout", dout, 0);

        xfer_start(8'hC4, 2'd1, 2'b00, 1'b0, 8'd1, 8'h00, 1'b1, 1'b1, 8'hC4);
        chk("post_rst ss_n", ss_n, 3'b101);
        xfer_finish(0, 36, "post_rst");
        chk("scoreboard empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_mode.md
SPI_MASTER_MODE -- requirements
Module: spi_master_mode

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning transfer word width in bits (>=2).
REQ-002 SHALL have parameter NCS, default 2, meaning number of slave-select lines (>=1).
REQ-003 SHALL have parameter DIV_W, default 8, meaning width of the clock-divider input.
REQ-004 clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr  input  1  start request, sampled each clk.
REQ-007 din  input  DWIDTH  transmit word.
REQ-008 cs_sel  input  $clog2(NCS) (min 1)  slave index.
REQ-009 mode  input  2  {CPOL, CPHA}.
REQ-010 lsb_first  input  1  1 = LSB shifted first, 0 = MSB first.
REQ-011 div  input  DIV_W  half-period of sclk = div+1 clk cycles.
REQ-012 dout  output  DWIDTH  last received word.
REQ-013 busy  output  1  transfer in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 miso  input  1  serial data in; mosi  output  1  serial data out.
REQ-016 sclk  output  1  serial clock; ss_n  output  NCS  active-low slave selects.

Function
REQ-017 States SHALL be IDLE, SETUP, SHIFT, HOLD.
REQ-018 In IDLE, wr=1 with cs_sel<NCS SHALL be accepted: din, cs_sel, mode, lsb_first, div latched; next state SETUP; busy=1 and ss_n[cs_sel]=0 from the following cycle.
REQ-019 wr with cs_sel>=NCS SHALL be ignored; wr while busy SHALL be ignored; input changes while busy SHALL have no effect.
REQ-020 SETUP SHALL last div+1 cycles with sclk=CPOL, then enter SHIFT.
REQ-021 SHIFT SHALL toggle sclk every div+1 cycles, producing exactly 2*DWIDTH edges; odd edges are leading, even edges trailing.
REQ-022 CPHA=0: first bit SHALL be on mosi from SETUP entry; miso sampled on leading edges; next bit presented on trailing edges 2..2*DWIDTH-2.
REQ-023 CPHA=1: bit k SHALL be presented on leading edge 2k+1; miso sampled on trailing edges.
REQ-024 Bit order SHALL follow latched lsb_first for both mosi and received word assembly.
REQ-025 After the last edge, HOLD SHALL last div+1 cycles with sclk=CPOL and ss_n still asserted, then enter IDLE.
REQ-026 On HOLD->IDLE: ss_n SHALL go all-ones, busy=0, dout loaded with received word, done=1 for exactly that first IDLE cycle.
REQ-027 Total busy duration SHALL be (div+1)*(2*DWIDTH+2) cycles.
REQ-028 A wr in the done cycle SHALL be accepted (back-to-back transfers, ss_n deasserted at least one cycle between).
REQ-029 In IDLE, sclk SHALL track mode[1] with one-cycle register latency; mosi SHALL hold its last value.
REQ-030 sclk, mosi, ss_n SHALL be driven directly from registers (glitch-free).

Reset
REQ-031 rst=1 SHALL immediately force IDLE, sclk=0, mosi=0, ss_n all-ones, busy=0, done=0, dout=0, aborting any transfer without done.
REQ-032 First wr after rst deasserts SHALL be accepted normally.

Verification
REQ-033 DWIDTH=8, mode=00, MSB-first, div=1, din=0xA5, miso loopback from mosi -> 8 rising sclk edges, mosi=1,0,1,0,0,1,0,1; dout=0xA5; done after 36 busy cycles.
REQ-034 Modes 01,10,11 with din=0x3C and slave model returning 0xC3 -> dout=0xC3 each mode; idle sclk=CPOL; sampling edge per REQ-022/023.
REQ-035 lsb_first=1, din=0x01 -> mosi high only for first bit; slave returns 0x80 MSB-first-on-wire order -> dout=0x01.
REQ-036 NCS=2, cs_sel=1 -> only ss_n[1] low; cs_sel=2 (with NCS=3 build) -> ss_n[2]; wr with cs_sel>=NCS -> no busy.
REQ-037 wr during busy and in done cycle -> first ignored, second starts new transfer; ss_n high exactly one cycle between.
REQ-038 rst asserted at edge 5 -> ss_n all-ones, sclk=0, busy=0 asynchronously; no done pulse; dout unchanged from 0.
